// File: rtl/tower_placer_ctrl_pkg.sv
// Shared types and grid geometry for the tower-placer controller.
// The cell index packs (col,row) into a flat 0..47 occupancy address.
package tower_placer_ctrl_pkg;

    localparam int GRID_COLS = 8;
    localparam int GRID_ROWS = 6;
    localparam int CELL_PX   = 20;
    localparam int NUM_CELLS = GRID_COLS * GRID_ROWS;

    typedef enum logic [3:0] {
        RST_HOLD,
        INIT,
        DRAW_SQ,
        IDLE,
        ERASE_R,
        ERASE_D,
        MOVE_R,
        MOVE_D,
        MR_WAIT,
        MD_WAIT,
        ERASE_T,
        DRAW_T
    } state_e;

    function automatic logic [5:0] cell_index(input logic [2:0] col, input logic [2:0] row);
        return 6'(row) * 6'(GRID_COLS) + 6'(col);
    endfunction

endpackage

// File: rtl/tower_placer_ctrl_if.sv
// Request, datapath-feedback and datapath-control bundle of the controller.
// master is the controller side, slave is the keyboard/datapath side.
interface tower_placer_ctrl_if;

    logic       req_right;
    logic       req_down;
    logic       req_place;
    logic       valid;
    logic       square_done;
    logic       erase_square_done;
    logic       tower_done;
    logic       top_left;
    logic       draw_square;
    logic       move_right;
    logic       move_down;
    logic       move_right_wait;
    logic       move_down_wait;
    logic       draw_tower;
    logic       erase_square_right;
    logic       erase_square_down;
    logic       erase_square_tower;
    logic       busy;
    logic [2:0] cursor_col;
    logic [2:0] cursor_row;
    logic       place_ok;
    logic       place_reject;

    modport master (
        input  req_right, req_down, req_place, valid,
               square_done, erase_square_done, tower_done,
        output top_left, draw_square, move_right, move_down,
               move_right_wait, move_down_wait, draw_tower,
               erase_square_right, erase_square_down, erase_square_tower,
               busy, cursor_col, cursor_row, place_ok, place_reject
    );

    modport slave (
        output req_right, req_down, req_place, valid,
               square_done, erase_square_done, tower_done,
        input  top_left, draw_square, move_right, move_down,
               move_right_wait, move_down_wait, draw_tower,
               erase_square_right, erase_square_down, erase_square_tower,
               busy, cursor_col, cursor_row, place_ok, place_reject
    );

endinterface

// File: rtl/tower_placer_ctrl_occupancy_map.sv
// One bit per grid cell recording whether a tower already stands there.
// Clear wins over set so a reset during a tower commit leaves the map empty.
module tower_occupancy_map
    import tower_placer_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       clear_i,
    input  logic       set_en_i,
    input  logic [5:0] set_idx_i,
    input  logic [5:0] rd_idx_i,
    output logic       rd_bit_o
);

    logic [NUM_CELLS-1:0] occ_q;

    always_ff @(posedge clk) begin
        if (clear_i) begin
            occ_q <= '0;
        end else if (set_en_i) begin
            occ_q[set_idx_i] <= 1'b1;
        end
    end

    assign rd_bit_o = occ_q[rd_idx_i];

endmodule

// File: rtl/tower_placer_ctrl.sv
// Sequencer for the tower-placer datapath: turns key pulses into one-hot
// control strobes, tracks a shadow cursor and refuses placing on occupied cells.
module tower_placer_ctrl
    import tower_placer_ctrl_pkg::*;
#(
    parameter int DONE_GUARD = 2
) (
    input  logic               clk,
    input  logic               resetn,
    tower_placer_ctrl_if.master bus
);

    localparam int            DW      = $clog2(DONE_GUARD + 1);
    localparam logic [DW-1:0] GUARD   = DW'(DONE_GUARD);
    localparam logic [2:0]    COL_MAX = 3'(GRID_COLS - 1);
    localparam logic [2:0]    ROW_MAX = 3'(GRID_ROWS - 1);

    state_e        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [2:0]    col_q, col_d;
    logic [2:0]    row_q, row_d;
    logic          ok_q, ok_d;
    logic          rej_q, rej_d;
    logic          set_en;
    logic          occupied;
    logic          guard_ok;
    logic [5:0]    cur_idx;

    assign cur_idx  = cell_index(col_q, row_q);
    assign guard_ok = (dwell_q >= GUARD);

    tower_occupancy_map u_occ (
        .clk       (clk),
        .clear_i   (!resetn),
        .set_en_i  (set_en),
        .set_idx_i (cur_idx),
        .rd_idx_i  (cur_idx),
        .rd_bit_o  (occupied)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= RST_HOLD;
            dwell_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            ok_q    <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ok_q    <= ok_d;
            rej_q   <= rej_d;
        end
    end

    // Done flags are sticky in the datapath, so they only count after the guard dwell.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        ok_d    = 1'b0;
        rej_d   = 1'b0;
        set_en  = 1'b0;
        case (state_q)
            RST_HOLD: state_d = INIT;
            INIT:     state_d = DRAW_SQ;
            DRAW_SQ:  if (guard_ok && bus.square_done) state_d = IDLE;
            IDLE: begin
                if (bus.req_place) begin
                    if (occupied) rej_d   = 1'b1;
                    else          state_d = ERASE_T;
                end else if (bus.req_right) begin
                    state_d = ERASE_R;
                end else if (bus.req_down) begin
                    state_d = ERASE_D;
                end
            end
            ERASE_R:  if (guard_ok && bus.erase_square_done) state_d = MOVE_R;
            ERASE_D:  if (guard_ok && bus.erase_square_done) state_d = MOVE_D;
            MOVE_R: begin
                if (bus.valid) begin
                    col_d   = (col_q == COL_MAX) ? 3'd0 : col_q + 3'd1;
                    state_d = MR_WAIT;
                end
            end
            MOVE_D: begin
                if (bus.valid) begin
                    row_d   = (row_q == ROW_MAX) ? 3'd0 : row_q + 3'd1;
                    state_d = MD_WAIT;
                end
            end
            MR_WAIT,
            MD_WAIT:  state_d = DRAW_SQ;
            ERASE_T:  if (guard_ok && bus.erase_square_done) state_d = DRAW_T;
            DRAW_T: begin
                if (guard_ok && bus.tower_done) begin
                    set_en  = 1'b1;
                    ok_d    = 1'b1;
                    state_d = DRAW_SQ;
                end
            end
            default:  state_d = RST_HOLD;
        endcase
    end

    always_comb begin
        dwell_d = dwell_q;
        if (state_d != state_q) begin
            dwell_d = '0;
        end else if (dwell_q < GUARD) begin
            dwell_d = dwell_q + DW'(1);
        end
    end

    always_comb begin
        bus.top_left           = 1'b0;
        bus.draw_square        = 1'b0;
        bus.move_right         = 1'b0;
        bus.move_down          = 1'b0;
        bus.move_right_wait    = 1'b0;
        bus.move_down_wait     = 1'b0;
        bus.draw_tower         = 1'b0;
        bus.erase_square_right = 1'b0;
        bus.erase_square_down  = 1'b0;
        bus.erase_square_tower = 1'b0;
        case (state_q)
            INIT:    bus.top_left           = 1'b1;
            DRAW_SQ: bus.draw_square        = 1'b1;
            ERASE_R: bus.erase_square_right = 1'b1;
            ERASE_D: bus.erase_square_down  = 1'b1;
            MOVE_R:  bus.move_right         = 1'b1;
            MOVE_D:  bus.move_down          = 1'b1;
            MR_WAIT: bus.move_right_wait    = 1'b1;
            MD_WAIT: bus.move_down_wait     = 1'b1;
            ERASE_T: bus.erase_square_tower = 1'b1;
            DRAW_T:  bus.draw_tower         = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.cursor_col   = col_q;
    assign bus.cursor_row   = row_q;
    assign bus.place_ok     = ok_q;
    assign bus.place_reject = rej_q;

endmodule

// File: tb/tb_tower_placer_ctrl.sv
// Directed self-checking bench for tower_placer_ctrl: walks the cursor,
// places and rejects towers, and resets mid-draw.
module tb_tower_placer_ctrl;

    localparam logic [9:0] C_NONE  = 10'b0000000000;
    localparam logic [9:0] C_TOP   = 10'b1000000000;
    localparam logic [9:0] C_DSQ   = 10'b0100000000;
    localparam logic [9:0] C_MR    = 10'b0010000000;
    localparam logic [9:0] C_MD    = 10'b0001000000;
    localparam logic [9:0] C_MRW   = 10'b0000100000;
    localparam logic [9:0] C_MDW   = 10'b0000010000;
    localparam logic [9:0] C_DT    = 10'b0000001000;
    localparam logic [9:0] C_ER    = 10'b0000000100;
    localparam logic [9:0] C_ED    = 10'b0000000010;
    localparam logic [9:0] C_ET    = 10'b0000000001;

    logic clk;
    logic resetn;
    int   checkCount;
    int   failCount;

    tower_placer_ctrl_if bus ();

    tower_placer_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] ctrlVec();
        return {bus.top_left, bus.draw_square, bus.move_right, bus.move_down,
                bus.move_right_wait, bus.move_down_wait, bus.draw_tower,
                bus.erase_square_right, bus.erase_square_down, bus.erase_square_tower};
    endfunction

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkCursor(input string tag, input logic [2:0] col, input logic [2:0] row);
        checkOutput({tag, "_col"}, {7'd0, bus.cursor_col}, {7'd0, col});
        checkOutput({tag, "_row"}, {7'd0, bus.cursor_row}, {7'd0, row});
    endtask

    task automatic applyStimulus(input logic right, input logic down, input logic place);
        bus.req_right = right;
        bus.req_down  = down;
        bus.req_place = place;
        cycle();
        bus.req_right = 1'b0;
        bus.req_down  = 1'b0;
        bus.req_place = 1'b0;
    endtask

    // Called in the first DRAW_SQ cycle; returns with the FSM back in IDLE.
    task automatic drawSquare();
        checkOutput("dsq0", ctrlVec(), C_DSQ);
        bus.square_done = 1'b1;
        cycle();
        checkOutput("dsq1", ctrlVec(), C_DSQ);
        cycle();
        checkOutput("dsq2", ctrlVec(), C_DSQ);
        cycle();
        bus.square_done = 1'b0;
        checkOutput("idle_ctrl", ctrlVec(), C_NONE);
        checkOutput("idle_busy", {9'd0, bus.busy}, 10'd0);
    endtask

    task automatic doMove(input logic right, input logic [2:0] expCol, input logic [2:0] expRow);
        logic [9:0] eErase;
        logic [9:0] eMove;
        logic [9:0] eWait;
        eErase = right ? C_ER  : C_ED;
        eMove  = right ? C_MR  : C_MD;
        eWait  = right ? C_MRW : C_MDW;
        applyStimulus(right, !right, 1'b0);
        bus.erase_square_done = 1'b1;
        checkOutput("erase0", ctrlVec(), eErase);
        cycle();
        checkOutput("erase1", ctrlVec(), eErase);
        cycle();
        checkOutput("erase2", ctrlVec(), eErase);
        cycle();
        bus.erase_square_done = 1'b0;
        checkOutput("move0", ctrlVec(), eMove);
        cycle();
        checkOutput("moveHold", ctrlVec(), eMove);
        bus.valid = 1'b1;
        cycle();
        bus.valid = 1'b0;
        checkOutput("moveWait", ctrlVec(), eWait);
        checkCursor("move", expCol, expRow);
        cycle();
        drawSquare();
    endtask

    task automatic placeTower(input logic alsoRight);
        applyStimulus(alsoRight, 1'b0, 1'b1);
        bus.erase_square_done = 1'b1;
        checkOutput("et0", ctrlVec(), C_ET);
        cycle();
        checkOutput("et1", ctrlVec(), C_ET);
        cycle();
        checkOutput("et2", ctrlVec(), C_ET);
        cycle();
        bus.erase_square_done = 1'b0;
        bus.tower_done = 1'b1;
        checkOutput("dt0", ctrlVec(), C_DT);
        cycle();
        checkOutput("dt1", ctrlVec(), C_DT);
        checkOutput("dt1_ok", {9'd0, bus.place_ok}, 10'd0);
        cycle();
        checkOutput("dt2", ctrlVec(), C_DT);
        cycle();
        bus.tower_done = 1'b0;
        checkOutput("place_ok", {9'd0, bus.place_ok}, 10'd1);
        drawSquare();
        checkOutput("place_ok_end", {9'd0, bus.place_ok}, 10'd0);
    endtask

    task automatic placeReject();
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rej_pulse", {9'd0, bus.place_reject}, 10'd1);
        checkOutput("rej_ctrl", ctrlVec(), C_NONE);
        checkOutput("rej_busy", {9'd0, bus.busy}, 10'd0);
        cycle();
        checkOutput("rej_clear", {9'd0, bus.place_reject}, 10'd0);
        checkOutput("rej_busy2", {9'd0, bus.busy}, 10'd0);
    endtask

    task automatic startUp();
        checkOutput("init_top", ctrlVec(), C_TOP);
        bus.square_done = 1'b1;
        cycle();
        drawSquare();
        checkCursor("start", 3'd0, 3'd0);
    endtask

    initial begin
        checkCount            = 0;
        failCount             = 0;
        resetn                = 1'b0;
        bus.req_right         = 1'b0;
        bus.req_down          = 1'b0;
        bus.req_place         = 1'b0;
        bus.valid             = 1'b0;
        bus.square_done       = 1'b0;
        bus.erase_square_done = 1'b0;
        bus.tower_done        = 1'b0;
        cycle();
        cycle();
        $display("[TB] reset state");
        checkOutput("rst_ctrl", ctrlVec(), C_NONE);
        checkOutput("rst_busy", {9'd0, bus.busy}, 10'd1);
        checkOutput("rst_ok", {8'd0, bus.place_ok, bus.place_reject}, 10'd0);
        checkCursor("rst", 3'd0, 3'd0);

        resetn = 1'b1;
        cycle();
        startUp();

        $display("[TB] eight right moves with wrap");
        for (int i = 1; i <= 8; i++) begin
            doMove(1'b1, 3'(i % 8), 3'd0);
        end

        $display("[TB] six down moves with wrap");
        for (int i = 1; i <= 6; i++) begin
            doMove(1'b0, 3'd0, 3'(i % 6));
        end

        doMove(1'b1, 3'd1, 3'd0);
        doMove(1'b1, 3'd2, 3'd0);
        doMove(1'b1, 3'd3, 3'd0);
        doMove(1'b0, 3'd3, 3'd1);
        doMove(1'b0, 3'd3, 3'd2);

        $display("[TB] place then reject at (3,2)");
        placeTower(1'b0);
        placeReject();
        checkCursor("after_rej", 3'd3, 3'd2);

        $display("[TB] simultaneous right and place");
        doMove(1'b1, 3'd4, 3'd2);
        placeTower(1'b1);
        checkCursor("simul", 3'd4, 3'd2);
        placeReject();

        $display("[TB] reset during tower draw");
        doMove(1'b1, 3'd5, 3'd2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        bus.erase_square_done = 1'b1;
        cycle();
        cycle();
        cycle();
        bus.erase_square_done = 1'b0;
        checkOutput("mid_dt", ctrlVec(), C_DT);
        resetn = 1'b0;
        cycle();
        checkOutput("mid_rst_ctrl", ctrlVec(), C_NONE);
        checkOutput("mid_rst_busy", {9'd0, bus.busy}, 10'd1);
        checkCursor("mid_rst", 3'd0, 3'd0);
        resetn = 1'b1;
        cycle();
        startUp();

        $display("[TB] map cleared by reset");
        doMove(1'b1, 3'd1, 3'd0);
        doMove(1'b1, 3'd2, 3'd0);
        doMove(1'b1, 3'd3, 3'd0);
        doMove(1'b0, 3'd3, 3'd1);
        doMove(1'b0, 3'd3, 3'd2);
        placeTower(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
